// File: rtl/uart_wb_bridge.sv
// UART byte-frame command decoder driving single classic Wishbone read/write cycles.
// Frames: 'W' addr d3 d2 d1 d0 / 'R' addr; replies 'K' [+4 data bytes], 'E' or '?'.
module uart_wb_bridge #(
  parameter int unsigned WB_TIMEOUT = 1024,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned RX_TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rxData,
  input  logic        rxReady,
  input  logic        rxParityError,
  input  logic        rxProtocolError,
  output logic        clearFlags,
  output logic [7:0]  txData,
  output logic        startTx,
  input  logic        txReady,
  input  logic [31:0] wbRData,
  input  logic        wbAck,
  input  logic        wbErr,
  input  logic        wbRty,
  output logic        wbRst,
  output logic [7:0]  wbAddr,
  output logic [3:0]  wbSel,
  output logic        wbWe,
  output logic [31:0] wbWData,
  output logic        wbCycle,
  output logic        wbStrobe,
  output logic [2:0]  wbCti,
  output logic [1:0]  wbBte
);

  localparam int unsigned RXW = $clog2(RX_TIMEOUT + 1);
  localparam int unsigned WBW = $clog2(WB_TIMEOUT + 1);
  localparam int unsigned RTW = $clog2(MAX_RETRY + 2);
  localparam logic [RXW-1:0] RX_LAST  = RXW'(RX_TIMEOUT - 1);
  localparam logic [WBW-1:0] WB_LAST  = WBW'(WB_TIMEOUT - 1);
  localparam logic [RTW-1:0] RETRY_MX = RTW'(MAX_RETRY);

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_UNK = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_GET_ADDR    = 3'd1,
    S_GET_DATA    = 3'd2,
    S_WB_CYCLE    = 3'd3,
    S_SEND_STATUS = 3'd4,
    S_SEND_DATA   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    TX_SEND = 2'd0,
    TX_FALL = 2'd1,
    TX_RISE = 2'd2
  } tx_ph_e;

  state_e         state_q, state_d;
  tx_ph_e         tx_ph_q, tx_ph_d;
  logic           we_q, we_d;
  logic [7:0]     addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [7:0]     status_q, status_d;
  logic [1:0]     byte_cnt_q, byte_cnt_d;
  logic [RXW-1:0] rx_cnt_q, rx_cnt_d;
  logic [WBW-1:0] wb_cnt_q, wb_cnt_d;
  logic [RTW-1:0] retry_q, retry_d;
  logic           cyc_q, cyc_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           start_tx_q, start_tx_d;
  logic           clear_q, clear_d;

  logic           rx_err_s, rx_tmo_s, cmd_ok_s;
  logic           wb_err_s, wb_rty_s, wb_ack_s, wb_tmo_s, wb_done_s, retry_last_s;
  logic           tx_done_s;
  logic [7:0]     tx_byte_s;

  // Sticky UART flags stay high until our clear lands, so ignore them while the clear pulse is out.
  assign rx_err_s     = (rxParityError | rxProtocolError) & ~clear_q;
  assign rx_tmo_s     = (rx_cnt_q == RX_LAST);
  assign cmd_ok_s     = (rxData == CMD_WR) | (rxData == CMD_RD);
  assign wb_err_s     = cyc_q & wbErr;
  assign wb_rty_s     = cyc_q & ~wbErr & wbRty;
  assign wb_ack_s     = cyc_q & ~wbErr & ~wbRty & wbAck;
  assign wb_tmo_s     = cyc_q & ~wbErr & ~wbRty & ~wbAck & (wb_cnt_q == WB_LAST);
  assign retry_last_s = (retry_q == RETRY_MX);
  assign wb_done_s    = wb_err_s | wb_ack_s | wb_tmo_s | (wb_rty_s & retry_last_s);
  assign tx_done_s    = (tx_ph_q == TX_RISE) & txReady;
  assign tx_byte_s    = (state_q == S_SEND_DATA) ? rdata_q[31:24] : status_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rx_err_s)     state_d = S_IDLE;
        else if (rxReady) state_d = cmd_ok_s ? S_GET_ADDR : S_SEND_STATUS;
        else              state_d = S_IDLE;
      end
      S_GET_ADDR: begin
        if (rx_err_s || rx_tmo_s) state_d = S_IDLE;
        else if (rxReady)         state_d = we_q ? S_GET_DATA : S_WB_CYCLE;
        else                      state_d = S_GET_ADDR;
      end
      S_GET_DATA: begin
        if (rx_err_s || rx_tmo_s)                state_d = S_IDLE;
        else if (rxReady && byte_cnt_q == 2'd3)  state_d = S_WB_CYCLE;
        else                                     state_d = S_GET_DATA;
      end
      S_WB_CYCLE: begin
        if (wb_done_s) state_d = S_SEND_STATUS;
        else           state_d = S_WB_CYCLE;
      end
      S_SEND_STATUS: begin
        if (tx_done_s) state_d = (!we_q && status_q == RSP_OK) ? S_SEND_DATA : S_IDLE;
        else           state_d = S_SEND_STATUS;
      end
      S_SEND_DATA: begin
        if (tx_done_s && byte_cnt_q == 2'd3) state_d = S_IDLE;
        else                                 state_d = S_SEND_DATA;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    status_d   = status_q;
    byte_cnt_d = byte_cnt_q;
    rx_cnt_d   = RXW'(0);
    wb_cnt_d   = wb_cnt_q;
    retry_d    = retry_q;
    cyc_d      = 1'b0;
    tx_ph_d    = tx_ph_q;
    tx_data_d  = tx_data_q;
    start_tx_d = 1'b0;
    clear_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        byte_cnt_d = 2'd0;
        retry_d    = RTW'(0);
        tx_ph_d    = TX_SEND;
        if (rx_err_s) begin
          clear_d = 1'b1;
        end else if (rxReady) begin
          if (cmd_ok_s) we_d     = (rxData == CMD_WR);
          else          status_d = RSP_UNK;
        end else begin
          we_d = we_q;
        end
      end
      S_GET_ADDR, S_GET_DATA: begin
        if (rx_err_s) begin
          clear_d = 1'b1;
        end else if (rx_tmo_s) begin
          rx_cnt_d = RXW'(0);
        end else if (rxReady) begin
          if (state_q == S_GET_ADDR) begin
            addr_d = rxData;
          end else begin
            wdata_d    = {wdata_q[23:0], rxData};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + RXW'(1);
        end
      end
      S_WB_CYCLE: begin
        // A low cyc_q here is either entry or the one idle cycle after a retry: (re)issue.
        if (!cyc_q) begin
          cyc_d    = 1'b1;
          wb_cnt_d = WBW'(0);
        end else if (wb_err_s) begin
          status_d = RSP_ERR;
        end else if (wb_rty_s) begin
          if (retry_last_s) status_d = RSP_ERR;
          else              retry_d  = retry_q + RTW'(1);
        end else if (wb_ack_s) begin
          status_d = RSP_OK;
          rdata_d  = we_q ? rdata_q : wbRData;
        end else if (wb_tmo_s) begin
          status_d = RSP_ERR;
        end else begin
          cyc_d    = 1'b1;
          wb_cnt_d = wb_cnt_q + WBW'(1);
        end
      end
      S_SEND_STATUS, S_SEND_DATA: begin
        case (tx_ph_q)
          TX_SEND: begin
            if (txReady) begin
              start_tx_d = 1'b1;
              tx_data_d  = tx_byte_s;
              tx_ph_d    = TX_FALL;
              rdata_d    = (state_q == S_SEND_DATA) ? {rdata_q[23:0], 8'h00} : rdata_q;
            end else begin
              tx_ph_d = TX_SEND;
            end
          end
          TX_FALL: tx_ph_d = txReady ? TX_FALL : TX_RISE;
          TX_RISE: begin
            if (txReady) begin
              tx_ph_d    = TX_SEND;
              byte_cnt_d = (state_q == S_SEND_STATUS) ? 2'd0 : byte_cnt_q + 2'd1;
            end else begin
              tx_ph_d = TX_RISE;
            end
          end
          default: tx_ph_d = TX_SEND;
        endcase
      end
      default: tx_ph_d = TX_SEND;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ph_q    <= TX_SEND;
      we_q       <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 32'h0000_0000;
      rdata_q    <= 32'h0000_0000;
      status_q   <= 8'h00;
      byte_cnt_q <= 2'd0;
      rx_cnt_q   <= RXW'(0);
      wb_cnt_q   <= WBW'(0);
      retry_q    <= RTW'(0);
      cyc_q      <= 1'b0;
      tx_data_q  <= 8'h00;
      start_tx_q <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      tx_ph_q    <= tx_ph_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      status_q   <= status_d;
      byte_cnt_q <= byte_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
      retry_q    <= retry_d;
      cyc_q      <= cyc_d;
      tx_data_q  <= tx_data_d;
      start_tx_q <= start_tx_d;
      clear_q    <= clear_d;
    end
  end

  // Reset must kill an in-flight bus cycle immediately, not at the next edge.
  assign wbCycle    = cyc_q & ~rst;
  assign wbStrobe   = cyc_q & ~rst;
  assign wbWe       = we_q;
  assign wbAddr     = addr_q;
  assign wbWData    = wdata_q;
  assign wbSel      = 4'hF;
  assign wbCti      = 3'b000;
  assign wbBte      = 2'b00;
  assign wbRst      = rst;
  assign txData     = tx_data_q;
  assign startTx    = start_tx_q;
  assign clearFlags = clear_q;

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Directed bench for uart_wb_bridge: UART tx and Wishbone slave models with scoreboard queues.
module tb_uart_wb_bridge;

  localparam int WBT = 40;
  localparam int MR  = 3;
  localparam int RXT = 300;
  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_RTY  = 2;
  localparam int K_NONE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rxData = 8'h00;
  logic        rxReady = 1'b0;
  logic        rxParityError = 1'b0;
  logic        rxProtocolError = 1'b0;
  logic        clearFlags;
  logic [7:0]  txData;
  logic        startTx;
  logic        txReady = 1'b1;
  logic [31:0] wbRData = 32'h0;
  logic        wbAck = 1'b0;
  logic        wbErr = 1'b0;
  logic        wbRty = 1'b0;
  logic        wbRst;
  logic [7:0]  wbAddr;
  logic [3:0]  wbSel;
  logic        wbWe;
  logic [31:0] wbWData;
  logic        wbCycle;
  logic        wbStrobe;
  logic [2:0]  wbCti;
  logic [1:0]  wbBte;

  always #5 clk = ~clk;

  uart_wb_bridge #(.WB_TIMEOUT(WBT), .MAX_RETRY(MR), .RX_TIMEOUT(RXT)) dut (
    .clk(clk), .rst(rst), .rxData(rxData), .rxReady(rxReady),
    .rxParityError(rxParityError), .rxProtocolError(rxProtocolError),
    .clearFlags(clearFlags), .txData(txData), .startTx(startTx), .txReady(txReady),
    .wbRData(wbRData), .wbAck(wbAck), .wbErr(wbErr), .wbRty(wbRty), .wbRst(wbRst),
    .wbAddr(wbAddr), .wbSel(wbSel), .wbWe(wbWe), .wbWData(wbWData),
    .wbCycle(wbCycle), .wbStrobe(wbStrobe), .wbCti(wbCti), .wbBte(wbBte)
  );

  typedef struct { int kind; int delay; logic [31:0] data; } resp_t;
  typedef struct { logic [7:0] addr; logic we; logic [31:0] wdata; } wbx_t;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_tx[$];
  resp_t      resp_q[$];
  wbx_t       exp_wb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // UART transmitter model: busy for a few cycles after each start request.
  int tx_hold = 0;
  int n_tx = 0;
  always @(negedge clk) begin
    if (rst) begin
      txReady = 1'b1;
      tx_hold = 0;
    end else if (startTx) begin
      n_tx++;
      chk("tx_ready_at_start", txReady, 1);
      chk("tx_byte_expected", exp_tx.size() > 0, 1);
      if (exp_tx.size() > 0) chk("tx_byte", txData, exp_tx.pop_front());
      txReady = 1'b0;
      tx_hold = 4;
    end else if (tx_hold > 0) begin
      tx_hold--;
      if (tx_hold == 0) txReady = 1'b1;
    end
  end

  // Wishbone slave model: one scripted response per issued cycle, plus gap/hold measurement.
  resp_t cur;
  wbx_t  wx;
  int    cnt = 0;
  bit    busy = 1'b0;
  bit    prev_cyc = 1'b0;
  bit    last_rty = 1'b0;
  int    low_cnt = 0;
  int    hold_cnt = 0;
  int    last_hold = 0;
  int    bad_gaps = 0;
  int    n_issue = 0;
  always @(negedge clk) begin
    wbAck = 1'b0;
    wbErr = 1'b0;
    wbRty = 1'b0;
    if (wbCycle) begin
      if (!prev_cyc) begin
        n_issue++;
        if (last_rty && low_cnt != 1) bad_gaps++;
        last_rty = 1'b0;
        chk("wb_strobe", wbStrobe, 1);
        chk("wb_cycle_expected", exp_wb.size() > 0, 1);
        if (exp_wb.size() > 0) begin
          wx = exp_wb.pop_front();
          chk("wb_addr", wbAddr, wx.addr);
          chk("wb_we", wbWe, wx.we);
          if (wx.we) chk("wb_wdata", wbWData, wx.wdata);
        end
        if (resp_q.size() > 0) cur = resp_q.pop_front();
        else begin cur.kind = K_NONE; cur.delay = 0; cur.data = 32'h0; end
        cnt  = 0;
        busy = 1'b1;
      end
      hold_cnt++;
      if (busy && cur.kind != K_NONE) begin
        if (cnt == cur.delay) begin
          busy    = 1'b0;
          wbRData = cur.data;
          case (cur.kind)
            K_ACK:   wbAck = 1'b1;
            K_ERR:   wbErr = 1'b1;
            default: begin wbRty = 1'b1; last_rty = 1'b1; end
          endcase
        end else begin
          cnt++;
        end
      end
    end else begin
      if (prev_cyc) begin
        last_hold = hold_cnt;
        hold_cnt  = 0;
        low_cnt   = 1;
      end else begin
        low_cnt++;
      end
    end
    prev_cyc = wbCycle;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rxData  = b;
    rxReady = 1'b1;
    @(negedge clk);
    rxReady = 1'b0;
    rxData  = 8'h00;
    tick(2);
  endtask

  task automatic resp(input int k, input int d, input logic [31:0] data);
    resp_t r;
    r.kind = k; r.delay = d; r.data = data;
    resp_q.push_back(r);
  endtask

  task automatic exp_cycle(input logic [7:0] a, input logic we, input logic [31:0] wd);
    wbx_t w;
    w.addr = a; w.we = we; w.wdata = wd;
    exp_wb.push_back(w);
  endtask

  task automatic exp_read_ok(input logic [31:0] d);
    exp_tx.push_back(8'h4B);
    exp_tx.push_back(d[31:24]);
    exp_tx.push_back(d[23:16]);
    exp_tx.push_back(d[15:8]);
    exp_tx.push_back(d[7:0]);
  endtask

  task automatic wait_done(input string tag);
    int i;
    i = 0;
    while ((exp_tx.size() > 0 || !txReady || wbCycle) && i < 3000) begin
      @(negedge clk);
      i++;
    end
    tick(4);
    chk({tag, "_tx_drained"}, exp_tx.size(), 0);
    chk({tag, "_wb_drained"}, exp_wb.size(), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wbCycle"}, wbCycle, 0);
    chk({tag, "_wbStrobe"}, wbStrobe, 0);
    chk({tag, "_startTx"}, startTx, 0);
    chk({tag, "_clearFlags"}, clearFlags, 0);
    chk({tag, "_txData"}, txData, 0);
    chk({tag, "_wbAddr"}, wbAddr, 0);
    chk({tag, "_wbWData"}, wbWData, 0);
    chk({tag, "_wbWe"}, wbWe, 0);
    chk({tag, "_wbRst"}, wbRst, 1);
    chk({tag, "_wbSel"}, wbSel, 4'hF);
    chk({tag, "_wbCti"}, wbCti, 3'b000);
    chk({tag, "_wbBte"}, wbBte, 2'b00);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  int t0, i0, pulses, w;
  initial begin
    tick(3);
    chk_reset("rst");
    rst = 1'b0;
    #1 chk("rst_release_wbRst", wbRst, 0);

    // Write with ack after 2 cycles.
    exp_cycle(8'h10, 1'b1, 32'hDEADBEEF);
    resp(K_ACK, 2, 32'h0);
    exp_tx.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h10);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    wait_done("write");

    // Plain read.
    exp_cycle(8'h20, 1'b0, 32'h0);
    resp(K_ACK, 0, 32'h12345678);
    exp_read_ok(32'h12345678);
    send_byte(8'h52); send_byte(8'h20);
    wait_done("read");

    // Read retried twice then acked.
    i0 = n_issue;
    bad_gaps = 0;
    repeat (3) exp_cycle(8'h30, 1'b0, 32'h0);
    resp(K_RTY, 1, 32'h0); resp(K_RTY, 0, 32'h0); resp(K_ACK, 1, 32'hCAFEBABE);
    exp_read_ok(32'hCAFEBABE);
    send_byte(8'h52); send_byte(8'h30);
    wait_done("retry2");
    chk("retry2_issues", n_issue - i0, 3);
    chk("retry2_gaps", bad_gaps, 0);

    // Retry exhausted.
    i0 = n_issue;
    repeat (MR + 1) begin exp_cycle(8'h31, 1'b0, 32'h0); resp(K_RTY, 0, 32'h0); end
    exp_tx.push_back(8'h45);
    send_byte(8'h52); send_byte(8'h31);
    wait_done("retry_exh");
    chk("retry_exh_issues", n_issue - i0, MR + 1);
    chk("retry_exh_gaps", bad_gaps, 0);

    // Unresponsive slave.
    exp_cycle(8'h11, 1'b1, 32'h01020304);
    exp_tx.push_back(8'h45);
    send_byte(8'h57); send_byte(8'h11);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_done("wb_timeout");
    chk("wb_timeout_hold", last_hold, WBT);

    // Slave error, and error winning over a simultaneous-looking ack path.
    exp_cycle(8'h12, 1'b1, 32'hA5A55A5A);
    resp(K_ERR, 1, 32'h0);
    exp_tx.push_back(8'h45);
    send_byte(8'h57); send_byte(8'h12);
    send_byte(8'hA5); send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h5A);
    wait_done("wb_err");

    // Unknown command.
    exp_tx.push_back(8'h3F);
    send_byte(8'h41);
    wait_done("unknown");

    // Inter-byte timeout drops the partial frame silently.
    t0 = n_tx;
    send_byte(8'h57); send_byte(8'h10); send_byte(8'hAA);
    tick(RXT + 50);
    chk("rx_timeout_silent", n_tx - t0, 0);
    exp_cycle(8'h20, 1'b0, 32'h0);
    resp(K_ACK, 0, 32'h0BADF00D);
    exp_read_ok(32'h0BADF00D);
    send_byte(8'h52); send_byte(8'h20);
    wait_done("after_rx_timeout");

    // Parity error mid-frame.
    t0 = n_tx;
    pulses = 0;
    send_byte(8'h57);
    @(negedge clk);
    rxParityError = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (clearFlags) begin
        pulses++;
        rxParityError = 1'b0;
      end
    end
    chk("parity_clear_pulses", pulses, 1);
    tick(20);
    chk("parity_silent", n_tx - t0, 0);
    exp_cycle(8'h21, 1'b0, 32'h0);
    resp(K_ACK, 0, 32'h89ABCDEF);
    exp_read_ok(32'h89ABCDEF);
    send_byte(8'h52); send_byte(8'h21);
    wait_done("after_parity");

    // Reset during a bus cycle.
    t0 = n_tx;
    exp_cycle(8'h40, 1'b0, 32'h0);
    send_byte(8'h52); send_byte(8'h40);
    w = 0;
    while (!wbCycle && w < 50) begin @(negedge clk); w++; end
    chk("midrst_cycle_seen", wbCycle, 1);
    tick(3);
    rst = 1'b1;
    #1;
    chk("midrst_cyc_now", wbCycle, 0);
    chk("midrst_stb_now", wbStrobe, 0);
    @(posedge clk);
    #1 chk_reset("midrst");
    tick(2);
    rst = 1'b0;
    tick(30);
    chk("midrst_silent", n_tx - t0, 0);
    exp_cycle(8'h50, 1'b0, 32'h0);
    resp(K_ACK, 0, 32'h55AA33CC);
    exp_read_ok(32'h55AA33CC);
    send_byte(8'h52); send_byte(8'h50);
    wait_done("after_midrst");
    chk("resp_queue_empty", resp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_wb_bridge.md
Name: uart_wb_bridge

Overview:
- Command decoder and Wishbone master between the UART core byte interface and the miner register file.
- Assembles byte frames from the UART receiver into single classic Wishbone read/write cycles.
- Returns status and read data through the UART transmitter.
- Sits directly downstream of the UART core and upstream of the miner Wishbone slave, inside the miner UART top level.

Parameters:
- WB_TIMEOUT, 1024, Wishbone cycles to wait for ack/err/rty before aborting with error status.
- MAX_RETRY, 3, number of times a cycle is re-issued after wbRty before it is reported as an error.
- RX_TIMEOUT, 100000, clock cycles allowed between bytes of one frame before the partial frame is discarded.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rxData  in  8  received byte, valid only when rxReady is high
- rxReady  in  1  one-cycle pulse per received byte
- rxParityError  in  1  sticky flag from the UART core
- rxProtocolError  in  1  sticky flag from the UART core
- clearFlags  out  1  one-cycle pulse that clears the UART error flags
- txData  out  8  byte to transmit
- startTx  out  1  one-cycle transmit request
- txReady  in  1  transmitter idle
- wbRData  in  32  Wishbone read data
- wbAck  in  1  Wishbone acknowledge
- wbErr  in  1  Wishbone error
- wbRty  in  1  Wishbone retry
- wbRst  out  1  Wishbone reset
- wbAddr  out  8  Wishbone address
- wbSel  out  4  Wishbone byte select
- wbWe  out  1  Wishbone write enable
- wbWData  out  32  Wishbone write data
- wbCycle  out  1  Wishbone cycle
- wbStrobe  out  1  Wishbone strobe
- wbCti  out  3  Wishbone cycle type identifier
- wbBte  out  2  Wishbone burst type extension

Behaviour:
- Single clock domain (clk). Reset is synchronous, active-high (rst). On reset:
  - state=IDLE, all counters=0.
  - clearFlags=0, startTx=0, txData=0.
  - wbCycle=0, wbStrobe=0, wbWe=0, wbAddr=0, wbWData=0.
- Constant outputs: wbSel=4'hF, wbCti=3'b000, wbBte=2'b00, wbRst=rst (combinational).
- Frame formats:
  - Write: 0x57, addr, d3, d2, d1, d0 (data is most-significant byte first).
  - Read: 0x52, addr.
- Responses:
  - Success: 0x4B ('K'); a read success is followed by 4 data bytes, most-significant byte first.
  - Failure (err, retry exhausted, timeout): 0x45 ('E'), with no data bytes.
  - Unknown command byte: 0x3F ('?').
- States: IDLE, GET_ADDR, GET_DATA, WB_CYCLE, SEND_STATUS, SEND_DATA.
- IDLE:
  - On rxReady with 0x57 or 0x52: latch wbWe=(byte==0x57), go to GET_ADDR.
  - Any other byte: load 0x3F as the status byte, go to SEND_STATUS.
- GET_ADDR: on rxReady, latch wbAddr. Write goes to GET_DATA with byte count 0; read goes to WB_CYCLE.
- GET_DATA: each rxReady shifts the byte into wbWData from the LSB end. After the 4th byte, go to WB_CYCLE.
- Inter-byte timeout:
  - In GET_ADDR and GET_DATA a counter counts cycles since the last byte.
  - Reaching RX_TIMEOUT discards the frame and returns to IDLE with no response.
- WB_CYCLE:
  - wbCycle and wbStrobe are asserted the cycle after entry and held until the cycle terminates.
  - Termination is sampled on the first cycle with ack, err or rty high.
  - ack: on a read, latch wbRData; status 0x4B.
  - err: status 0x45.
  - Priority when several are high together: err > rty > ack.
  - rty: deassert wbCycle/wbStrobe for exactly 1 cycle, then re-issue. After MAX_RETRY re-issues, a further rty gives status 0x45.
  - Timeout: the counter restarts on each issue. Reaching WB_TIMEOUT with no response drops wbCycle/wbStrobe; status 0x45.
  - wbCycle and wbStrobe are 0 in the cycle after termination. Then go to SEND_STATUS.
- SEND_STATUS:
  - When txReady=1, drive txData=status and pulse startTx for 1 cycle.
  - startTx must never pulse while txReady=0.
  - After the pulse, wait for txReady to fall then rise before the next byte.
  - Read with 0x4B goes to SEND_DATA; all other cases return to IDLE.
- SEND_DATA: sends the 4 latched bytes, most-significant byte first, with the same txReady handshake, then returns to IDLE.
- Bytes received while in WB_CYCLE, SEND_STATUS or SEND_DATA are dropped.
- UART errors: rxParityError or rxProtocolError seen in any receive state (IDLE, GET_ADDR, GET_DATA):
  - Pulse clearFlags for 1 cycle.
  - Discard the partial frame, return to IDLE; no response.
  - The error takes priority over a simultaneous rxReady.
- Reset mid-operation: reset during WB_CYCLE drops wbCycle/wbStrobe in the same cycle as the reset is applied. No response byte is sent after reset.

Test Plan:
- Write frame 57 10 DE AD BE EF, slave acks after 2 cycles -> one write cycle with wbAddr=0x10, wbWData=0xDEADBEEF, wbWe=1; UART sends 4B.
- Read frame 52 20, slave returns 0x12345678 with ack -> wbWe=0; UART sends 4B 12 34 56 78 in order, each startTx only while txReady=1.
- Read frame 52 30 with slave rty on first 2 attempts then ack 0xCAFEBABE -> three cycles with a 1-cycle gap between attempts; response 4B CA FE BA BE. With rty 4 times in a row -> 45.
- Write to an unresponsive slave -> wbCycle held for WB_TIMEOUT cycles then dropped; UART sends 45. A slave asserting wbErr -> 45.
- Byte 0x41 -> response 3F. Frame 57 10 AA then silence for RX_TIMEOUT -> no response; a following 52 20 works normally.
- rxParityError raised after 57 -> clearFlags pulses once, no response. rst asserted during WB_CYCLE -> all outputs at their reset values; a subsequent read completes correctly.
